// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer between the ball/paddle logic and scorer.
// Turns goal levels into one-cycle score pulses, holds the ball for a serve
// delay before every rally, keeps per-player points and declares the winner.
// Optional feature macro: PONG_MATCH_WIN_BY_TWO_EN (win needs a 2-point lead,
// with 15 points as a hard cap). Undefined: first to WIN_POINTS wins.
module pong_match_ctrl #(
   parameter int WIN_POINTS  = 5,
   parameter int SERVE_DELAY = 50_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       goal_A,
   input  logic       goal_B,
   input  logic       btn_start,
   output logic       score_A,
   output logic       score_B,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] points_A,
   output logic [3:0] points_B,
   output logic       game_over,
   output logic       winner
);

   localparam int             CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(SERVE_DELAY - 1);
   localparam logic [4:0]     WIN_PTS    = 5'(WIN_POINTS);

   typedef enum logic [2:0] {
      IDLE,
      SERVE_WAIT,
      PLAY,
      POINT,
      GAME_OVER
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             goal_a_q, goal_a_prev;
   logic             goal_b_q, goal_b_prev;
   logic             start_q, start_prev;
   logic             goal_a_rise, goal_b_rise, start_rise;

   logic             score_a_nxt, score_b_nxt, ball_reset_nxt, serve_dir_nxt;
   logic [3:0]       points_a_nxt, points_b_nxt;
   logic             game_over_nxt, winner_nxt;

   logic [4:0]       pa, pb;
   logic             won_a, won_b;

   // Sample the raw inputs and keep the previous sample for edge detection
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         goal_a_q    <= 1'b0;
         goal_a_prev <= 1'b0;
         goal_b_q    <= 1'b0;
         goal_b_prev <= 1'b0;
         start_q     <= 1'b0;
         start_prev  <= 1'b0;
      end else begin
         goal_a_q    <= goal_A;
         goal_a_prev <= goal_a_q;
         goal_b_q    <= goal_B;
         goal_b_prev <= goal_b_q;
         start_q     <= btn_start;
         start_prev  <= start_q;
      end
   end

   assign goal_a_rise = goal_a_q & ~goal_a_prev;
   assign goal_b_rise = goal_b_q & ~goal_b_prev;
   assign start_rise  = start_q & ~start_prev;

   assign pa = {1'b0, points_A};
   assign pb = {1'b0, points_B};

`ifdef PONG_MATCH_WIN_BY_TWO_EN
   assign won_a = (pa == 5'd15) || ((pa >= WIN_PTS) && (pa >= pb + 5'd2));
   assign won_b = (pb == 5'd15) || ((pb >= WIN_PTS) && (pb >= pa + 5'd2));
`else
   assign won_a = (pa >= WIN_PTS);
   assign won_b = (pb >= WIN_PTS);
`endif

   // Next-state and next-output logic; every output is registered from here
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      score_a_nxt   = 1'b0;
      score_b_nxt   = 1'b0;
      serve_dir_nxt = serve_dir;
      points_a_nxt  = points_A;
      points_b_nxt  = points_B;
      game_over_nxt = game_over;
      winner_nxt    = winner;

      case (state)
         IDLE: begin
            if (start_rise) begin
               points_a_nxt = 4'd0;
               points_b_nxt = 4'd0;
               cnt_nxt      = DELAY_LOAD;
               state_nxt    = SERVE_WAIT;
            end
         end
         SERVE_WAIT: begin
            if (cnt == '0) begin
               state_nxt = PLAY;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         PLAY: begin
            if (goal_a_rise && goal_b_rise) begin
               serve_dir_nxt = ~serve_dir;
               cnt_nxt       = DELAY_LOAD;
               state_nxt     = SERVE_WAIT;
            end else if (goal_a_rise) begin
               score_a_nxt   = 1'b1;
               points_a_nxt  = (points_A == 4'd15) ? 4'd15 : points_A + 4'd1;
               serve_dir_nxt = 1'b1;
               state_nxt     = POINT;
            end else if (goal_b_rise) begin
               score_b_nxt   = 1'b1;
               points_b_nxt  = (points_B == 4'd15) ? 4'd15 : points_B + 4'd1;
               serve_dir_nxt = 1'b0;
               state_nxt     = POINT;
            end
         end
         POINT: begin
            if (won_a) begin
               winner_nxt    = 1'b0;
               game_over_nxt = 1'b1;
               state_nxt     = GAME_OVER;
            end else if (won_b) begin
               winner_nxt    = 1'b1;
               game_over_nxt = 1'b1;
               state_nxt     = GAME_OVER;
            end else begin
               cnt_nxt   = DELAY_LOAD;
               state_nxt = SERVE_WAIT;
            end
         end
         GAME_OVER: begin
            if (start_rise) begin
               points_a_nxt  = 4'd0;
               points_b_nxt  = 4'd0;
               game_over_nxt = 1'b0;
               cnt_nxt       = DELAY_LOAD;
               state_nxt     = SERVE_WAIT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      ball_reset_nxt = (state_nxt != PLAY);
   end

   // State, counter and registered outputs
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         score_A    <= 1'b0;
         score_B    <= 1'b0;
         ball_reset <= 1'b1;
         serve_dir  <= 1'b0;
         points_A   <= 4'd0;
         points_B   <= 4'd0;
         game_over  <= 1'b0;
         winner     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         score_A    <= score_a_nxt;
         score_B    <= score_b_nxt;
         ball_reset <= ball_reset_nxt;
         serve_dir  <= serve_dir_nxt;
         points_A   <= points_a_nxt;
         points_B   <= points_b_nxt;
         game_over  <= game_over_nxt;
         winner     <= winner_nxt;
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for pong_match_ctrl with WIN_POINTS=3 and
// SERVE_DELAY=4. Inputs change and outputs are sampled 1 ns after the falling
// clock edge. The deuce scenario follows PONG_MATCH_WIN_BY_TWO_EN.
module tb_pong_match_ctrl;

   logic       clk_100MHz;
   logic       reset;
   logic       goal_A;
   logic       goal_B;
   logic       btn_start;
   logic       score_A;
   logic       score_B;
   logic       ball_reset;
   logic       serve_dir;
   logic [3:0] points_A;
   logic [3:0] points_B;
   logic       game_over;
   logic       winner;

   int checks = 0;
   int errors = 0;
   int pulse_a = 0;
   int pulse_b = 0;

   pong_match_ctrl #(
      .WIN_POINTS (3),
      .SERVE_DELAY(4)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .goal_A    (goal_A),
      .goal_B    (goal_B),
      .btn_start (btn_start),
      .score_A   (score_A),
      .score_B   (score_B),
      .ball_reset(ball_reset),
      .serve_dir (serve_dir),
      .points_A  (points_A),
      .points_B  (points_B),
      .game_over (game_over),
      .winner    (winner)
   );

   // 100 MHz clock
   initial begin
      clk_100MHz = 1'b0;
      forever #5 clk_100MHz = ~clk_100MHz;
   end

   // Advance n cycles, tallying score pulses seen once per cycle
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_100MHz);
         #1;
         pulse_a += int'(score_A);
         pulse_b += int'(score_B);
      end
   endtask

   // Wait for the serve to complete or the match to end, with a cycle budget
   task automatic wait_serve();
      int n;
      n = 0;
      while (ball_reset && !game_over && n < 40) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("[TB] FAIL wait_serve timeout ball_reset=%0b want 0", ball_reset);
      end
   endtask

   // Score one point for A (to_b=0) or B (to_b=1) from PLAY and wait for the next serve
   task automatic applyStimulus(input logic to_b);
      if (to_b) goal_B = 1'b1;
      else      goal_A = 1'b1;
      tick(2);
      goal_A = 1'b0;
      goal_B = 1'b0;
      tick(1);
      wait_serve();
   endtask

   // Fresh match: reset pulse, start press, wait until play
   task automatic new_match();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      wait_serve();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks++; if (score_A !== 1'b0 || score_B !== 1'b0) begin errors++; $display("[TB] FAIL rst_pulses got %0b%0b want 00", score_A, score_B); end
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL rst_ball_reset got %0b want 1", ball_reset); end
      checks++; if (serve_dir !== 1'b0) begin errors++; $display("[TB] FAIL rst_serve_dir got %0b want 0", serve_dir); end
      checks++; if (points_A !== 4'd0 || points_B !== 4'd0) begin errors++; $display("[TB] FAIL rst_points got %0d/%0d want 0/0", points_A, points_B); end
      checks++; if (game_over !== 1'b0 || winner !== 1'b0) begin errors++; $display("[TB] FAIL rst_game got %0b/%0b want 0/0", game_over, winner); end
      reset = 1'b0;
      tick(3);
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL idle_ball_reset got %0b want 1", ball_reset); end
   endtask

   task automatic test_basic_point();
      int pa0, first, br_cnt;
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      tick(4);
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL serve_hold got %0b want 1", ball_reset); end
      tick(1);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL serve_release got %0b want 0", ball_reset); end
      pa0 = pulse_a;
      first = 0;
      br_cnt = 0;
      goal_A = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (score_A && first == 0) first = i;
         if (ball_reset) br_cnt++;
      end
      goal_A = 1'b0;
      checks++; if (pulse_a - pa0 !== 1) begin errors++; $display("[TB] FAIL basic_pulse_count got %0d want 1", pulse_a - pa0); end
      checks++; if (first !== 2) begin errors++; $display("[TB] FAIL basic_latency got %0d want 2", first); end
      checks++; if (br_cnt !== 5) begin errors++; $display("[TB] FAIL basic_hold_cycles got %0d want 5", br_cnt); end
      checks++; if (points_A !== 4'd1 || points_B !== 4'd0) begin errors++; $display("[TB] FAIL basic_points got %0d/%0d want 1/0", points_A, points_B); end
      checks++; if (serve_dir !== 1'b1) begin errors++; $display("[TB] FAIL basic_serve_dir got %0b want 1", serve_dir); end
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL basic_play got %0b want 0", ball_reset); end
      tick(1);
   endtask

   task automatic test_simultaneous();
      int pa0, pb0;
      pa0 = pulse_a;
      pb0 = pulse_b;
      goal_A = 1'b1;
      goal_B = 1'b1;
      tick(2);
      goal_A = 1'b0;
      goal_B = 1'b0;
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL void_serve_wait got %0b want 1", ball_reset); end
      checks++; if (serve_dir !== 1'b0) begin errors++; $display("[TB] FAIL void_serve_dir got %0b want 0", serve_dir); end
      tick(3);
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL void_hold got %0b want 1", ball_reset); end
      tick(1);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL void_release got %0b want 0", ball_reset); end
      checks++; if (pulse_a - pa0 !== 0 || pulse_b - pb0 !== 0) begin errors++; $display("[TB] FAIL void_pulses got %0d/%0d want 0/0", pulse_a - pa0, pulse_b - pb0); end
      checks++; if (points_A !== 4'd1 || points_B !== 4'd0) begin errors++; $display("[TB] FAIL void_points got %0d/%0d want 1/0", points_A, points_B); end
   endtask

   task automatic test_ignored();
      int pa0, pb0;
      pa0 = pulse_a;
      pb0 = pulse_b;
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      tick(3);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL start_in_play got %0b want 0", ball_reset); end
      checks++; if (points_A !== 4'd1 || points_B !== 4'd0) begin errors++; $display("[TB] FAIL start_in_play_points got %0d/%0d want 1/0", points_A, points_B); end
      goal_B = 1'b1;
      tick(2);
      goal_B = 1'b0;
      checks++; if (score_B !== 1'b1 || points_B !== 4'd1) begin errors++; $display("[TB] FAIL b_point got %0b/%0d want 1/1", score_B, points_B); end
      checks++; if (serve_dir !== 1'b0) begin errors++; $display("[TB] FAIL b_serve_dir got %0b want 0", serve_dir); end
      tick(1);
      goal_A = 1'b1;
      tick(2);
      goal_A = 1'b0;
      tick(1);
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL goal_in_wait_hold got %0b want 1", ball_reset); end
      tick(1);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL goal_in_wait_release got %0b want 0", ball_reset); end
      checks++; if (pulse_a - pa0 !== 0 || pulse_b - pb0 !== 1) begin errors++; $display("[TB] FAIL ignored_pulses got %0d/%0d want 0/1", pulse_a - pa0, pulse_b - pb0); end
      checks++; if (points_A !== 4'd1 || points_B !== 4'd1) begin errors++; $display("[TB] FAIL ignored_points got %0d/%0d want 1/1", points_A, points_B); end
   endtask

   task automatic test_deuce();
      new_match();
`ifdef PONG_MATCH_WIN_BY_TWO_EN
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      end
      checks++; if (points_A !== 4'd3 || points_B !== 4'd3 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL deuce_3_3 got %0d/%0d go=%0b want 3/3 go=0", points_A, points_B, game_over); end
      applyStimulus(1'b0);
      checks++; if (points_A !== 4'd4 || game_over !== 1'b0 || ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL deuce_4_3 got %0d go=%0b br=%0b want 4 go=0 br=0", points_A, game_over, ball_reset); end
      goal_A = 1'b1;
      tick(2);
      goal_A = 1'b0;
      checks++; if (score_A !== 1'b1 || points_A !== 4'd5 || points_B !== 4'd3 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL deuce_5_3_point got %0b %0d/%0d go=%0b want 1 5/3 go=0", score_A, points_A, points_B, game_over); end
`else
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0);
         applyStimulus(1'b1);
      end
      checks++; if (points_A !== 4'd2 || points_B !== 4'd2 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL tie_2_2 got %0d/%0d go=%0b want 2/2 go=0", points_A, points_B, game_over); end
      goal_A = 1'b1;
      tick(2);
      goal_A = 1'b0;
      checks++; if (score_A !== 1'b1 || points_A !== 4'd3 || points_B !== 4'd2 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL win_3_2_point got %0b %0d/%0d go=%0b want 1 3/2 go=0", score_A, points_A, points_B, game_over); end
`endif
      tick(1);
      checks++; if (game_over !== 1'b1 || winner !== 1'b0) begin errors++; $display("[TB] FAIL a_wins got go=%0b w=%0b want 1/0", game_over, winner); end
   endtask

   task automatic test_match_win();
      int pa0, pb0;
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      tick(1);
      checks++; if (points_A !== 4'd0 || points_B !== 4'd0 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart1 got %0d/%0d go=%0b want 0/0 go=0", points_A, points_B, game_over); end
      tick(4);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL restart1_play got %0b want 0", ball_reset); end
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      goal_B = 1'b1;
      tick(2);
      goal_B = 1'b0;
      checks++; if (score_B !== 1'b1 || points_B !== 4'd3 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL b_third_point got %0b %0d go=%0b want 1 3 go=0", score_B, points_B, game_over); end
      tick(1);
      checks++; if (game_over !== 1'b1 || winner !== 1'b1 || ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL b_wins got go=%0b w=%0b br=%0b want 1/1/1", game_over, winner, ball_reset); end
      pa0 = pulse_a;
      pb0 = pulse_b;
      goal_A = 1'b1;
      tick(3);
      goal_A = 1'b0;
      goal_B = 1'b1;
      tick(3);
      goal_B = 1'b0;
      tick(2);
      checks++; if (pulse_a - pa0 !== 0 || pulse_b - pb0 !== 0) begin errors++; $display("[TB] FAIL over_pulses got %0d/%0d want 0/0", pulse_a - pa0, pulse_b - pb0); end
      checks++; if (points_A !== 4'd0 || points_B !== 4'd3 || game_over !== 1'b1) begin errors++; $display("[TB] FAIL over_frozen got %0d/%0d go=%0b want 0/3 go=1", points_A, points_B, game_over); end
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      tick(1);
      checks++; if (points_B !== 4'd0 || game_over !== 1'b0 || ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL restart2 got %0d go=%0b br=%0b want 0 go=0 br=1", points_B, game_over, ball_reset); end
      tick(4);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL restart2_play got %0b want 0", ball_reset); end
   endtask

   task automatic test_reset_mid_play();
      int pa0;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      checks++; if (points_A !== 4'd2 || serve_dir !== 1'b1 || ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset got %0d sd=%0b br=%0b want 2 sd=1 br=0", points_A, serve_dir, ball_reset); end
      pa0 = pulse_a;
      goal_A = 1'b1;
      tick(1);
      reset = 1'b1;
      #1;
      checks++; if (points_A !== 4'd0 || serve_dir !== 1'b0 || ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL async_reset got %0d sd=%0b br=%0b want 0 sd=0 br=1", points_A, serve_dir, ball_reset); end
      checks++; if (winner !== 1'b0 || game_over !== 1'b0 || score_A !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_flags got w=%0b go=%0b sa=%0b want 0/0/0", winner, game_over, score_A); end
      tick(1);
      checks++; if (pulse_a - pa0 !== 0) begin errors++; $display("[TB] FAIL reset_drop_pulse got %0d want 0", pulse_a - pa0); end
      goal_A = 1'b0;
      reset = 1'b0;
      tick(3);
      btn_start = 1'b1;
      tick(1);
      btn_start = 1'b0;
      tick(4);
      checks++; if (ball_reset !== 1'b1) begin errors++; $display("[TB] FAIL idle_restart_hold got %0b want 1", ball_reset); end
      tick(1);
      checks++; if (ball_reset !== 1'b0) begin errors++; $display("[TB] FAIL idle_restart_play got %0b want 0", ball_reset); end
   endtask

   // Overall time limit so a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   // Scenario sequence
   initial begin
      reset     = 1'b1;
      goal_A    = 1'b0;
      goal_B    = 1'b0;
      btn_start = 1'b0;
      test_reset();
      test_basic_point();
      test_simultaneous();
      test_ignored();
      test_deuce();
      test_match_win();
      test_reset_mid_play();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer sitting between the ball/paddle logic and `scorer`. Turns raw goal levels into single-cycle `score_A`/`score_B` pulses for `scorer`. Holds the ball during serve delays and tracks per-player points to declare a winner. Supplies serve direction to the ball logic and restarts matches on a start button.

## Interface
- `WIN_POINTS`, default 5: points needed to win; legal range 1..15.
- `SERVE_DELAY`, default 50_000_000: cycles the ball is held at centre before each serve; minimum 1.
- `clk_100MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `goal_A`  in  1  level from ball logic: ball crossed B's edge, A scores. May stay high many cycles.
- `goal_B`  in  1  level: B scores.
- `btn_start`  in  1  start/restart request, already synchronised and debounced.
- `score_A`  out  1  one-cycle pulse to `scorer`.
- `score_B`  out  1  one-cycle pulse to `scorer`.
- `ball_reset`  out  1  high = ball held at centre and frozen.
- `serve_dir`  out  1  0 = serve toward A, 1 = serve toward B.
- `points_A`  out  4  A's points in the current match.
- `points_B`  out  4  B's points in the current match.
- `game_over`  out  1  match decided.
- `winner`  out  1  0 = A, 1 = B; valid while `game_over`.

## Operation
- States: IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
- Edge detectors on `goal_A`, `goal_B`, `btn_start`. The previous-sample registers reset to 0.
- IDLE:
  - `ball_reset`=1.
  - Rising `btn_start` clears points, loads the delay counter, and goes to SERVE_WAIT.
- SERVE_WAIT:
  - `ball_reset`=1.
  - Delay counter counts SERVE_DELAY cycles, then goes to PLAY.
  - Goal edges are ignored.
- PLAY:
  - `ball_reset`=0.
  - Rising `goal_A` only: pulse `score_A`, increment `points_A`, `serve_dir`←1 (serve toward the player who conceded, B), go to POINT.
  - Rising `goal_B` only: mirror image, `serve_dir`←0.
  - Both rising in the same cycle: void rally. No pulse, no point change, `serve_dir` toggles, go to SERVE_WAIT.
  - Goal levels held high without a new rising edge never score again.
- POINT (one cycle):
  - `ball_reset`=1.
  - Evaluate the win rule. If won: set `winner`, go to GAME_OVER.
  - Otherwise reload the delay counter and go to SERVE_WAIT.
- GAME_OVER:
  - `game_over`=1, `ball_reset`=1, points frozen.
  - Rising `btn_start` clears points and `game_over`, then goes to SERVE_WAIT (new match).
- `btn_start` edges in SERVE_WAIT, PLAY and POINT are ignored.
- Points saturate at 15.

## Timing
- Reset values:
  - state IDLE.
  - `score_A`=`score_B`=0.
  - `ball_reset`=1.
  - `serve_dir`=0.
  - `points_A`=`points_B`=0.
  - `game_over`=0, `winner`=0.
- All outputs are registered.
- Goal latency: a rising edge sampled at clock edge N (in PLAY) gives the score pulse, incremented points and state POINT, all visible after edge N+1. The pulse is exactly one cycle wide.
- POINT lasts exactly one cycle.
- The SERVE_WAIT to PLAY decision happens exactly SERVE_DELAY cycles after SERVE_WAIT entry, so `ball_reset` is high for SERVE_DELAY+1 cycles counting the POINT cycle.
- `game_over` rises in the cycle after POINT.
- Reset mid-operation: immediate return to reset values. Any in-flight pulse is dropped. `scorer` shares the same reset.

## Configuration
- `PONG_MATCH_WIN_BY_TWO_EN` defined:
  - A player wins when their points ≥ WIN_POINTS and lead ≥ 2.
  - Hard cap: the first player to reach 15 wins regardless of lead.
- `PONG_MATCH_WIN_BY_TWO_EN` undefined: the first player to reach WIN_POINTS wins.

## Test plan
- Reset: assert `reset` mid-PLAY with `points_A`=2.
  - → all outputs at reset values immediately, state IDLE, no score pulse.
- Basic point (WIN_POINTS=3, SERVE_DELAY=4):
  - Start, wait 4 cycles, raise `goal_A` and hold 20 cycles.
  - → exactly one `score_A` pulse, `points_A`=1, `serve_dir`=1, `ball_reset` high 5 cycles, then PLAY.
- Simultaneous goals: raise `goal_A` and `goal_B` in the same cycle during PLAY.
  - → no pulses, points unchanged, `serve_dir` toggled, SERVE_WAIT.
- Match win, macro undefined, WIN_POINTS=3: B scores 3 times.
  - → `game_over`=1, `winner`=1, `points_B`=3.
  - Further goals give no pulses. `btn_start` → points 0, SERVE_WAIT.
- Deuce, macro defined, WIN_POINTS=3: alternate points to 3-3, then A scores.
  - → 4-3, no game over. A scores again → 5-3, `game_over`=1, `winner`=0.
- Ignored inputs: `btn_start` pulse during PLAY, and a goal during SERVE_WAIT.
  - → no state change, no pulses, points unchanged.
